// File: rtl/mem_sync_ctrl.sv
// mem_sync_ctrl: unified instruction/data memory with a registered read path,
// ready/valid request handshake, programmable wait states, a hardware clear
// sequence after reset and address-range error reporting.
module mem_sync_ctrl #(
  parameter int WORD        = 8,
  parameter int LENGTH      = 32,
  parameter int ADDRESSL    = 5,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDRESSL-1:0] address,
  input  logic [WORD-1:0]     writeData,
  input  logic                memRead,
  input  logic                memWrite,
  output logic                ready,
  output logic [WORD-1:0]     readData,
  output logic                dataValid,
  output logic                rangeErr
);

  localparam int                 CNTW     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNTW-1:0]    CNT_LOAD = CNTW'(WAIT_CYCLES);
  localparam logic [ADDRESSL:0]  LEN_EXT  = (ADDRESSL + 1)'(LENGTH);
  localparam logic [ADDRESSL-1:0] LAST_IDX = ADDRESSL'(LENGTH - 1);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDRESSL-1:0] idx_q, idx_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [ADDRESSL-1:0] addr_q, addr_d;
  logic [WORD-1:0]     wdata_q, wdata_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [WORD-1:0]     rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [WORD-1:0]     mem_q [LENGTH];
  logic                mem_we;
  logic [ADDRESSL-1:0] mem_waddr;
  logic [WORD-1:0]     mem_wdata;
  logic                in_range;

  // Latched address is checked with one extra bit so LENGTH == 2**ADDRESSL works.
  assign in_range = ({1'b0, addr_q} < LEN_EXT);

  // Next-state logic: clear sweep, request accept, wait countdown, access.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = idx_q;
    mem_wdata = '0;
    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = idx_q;
        mem_wdata = '0;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (memRead || memWrite) begin
          addr_d  = address;
          wdata_d = writeData;
          rd_d    = memRead;
          wr_d    = memWrite;
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Read samples the old contents on the same edge the write lands,
          // giving read-before-write for combined requests.
          err_d = !in_range;
          if (rd_q) begin
            rdata_d = in_range ? mem_q[addr_q] : '0;
          end
          if (wr_q && in_range) begin
            mem_we    = 1'b1;
            mem_waddr = addr_q;
            mem_wdata = wdata_q;
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase
  end

  // Control and datapath registers; reset aborts any access and restarts the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CLEAR;
      idx_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array: contents are initialised by the clear sweep, not by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign dataValid = (state_q == S_DONE);
  assign rangeErr  = (state_q == S_DONE) && err_q;
  assign readData  = rdata_q;

endmodule

// File: tb/tb_mem_sync_ctrl.sv
// tb_mem_sync_ctrl: scoreboard bench for mem_sync_ctrl, one instance with
// LENGTH=32 and one with LENGTH=24 for range checks.
module tb_mem_sync_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] address;
  logic [7:0] writeData;
  logic       rd32, wr32, rd24, wr24;
  logic       ready32, dv32, err32;
  logic       ready24, dv24, err24;
  logic [7:0] readData32, readData24;

  always #5 clk = ~clk;

  mem_sync_ctrl #(.WORD(8), .LENGTH(32), .ADDRESSL(5), .WAIT_CYCLES(2)) dut32 (
    .clk(clk), .rst(rst), .address(address), .writeData(writeData),
    .memRead(rd32), .memWrite(wr32), .ready(ready32), .readData(readData32),
    .dataValid(dv32), .rangeErr(err32)
  );

  mem_sync_ctrl #(.WORD(8), .LENGTH(24), .ADDRESSL(5), .WAIT_CYCLES(2)) dut24 (
    .clk(clk), .rst(rst), .address(address), .writeData(writeData),
    .memRead(rd24), .memWrite(wr24), .ready(ready24), .readData(readData24),
    .dataValid(dv24), .rangeErr(err24)
  );

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         tag;
  } exp_t;

  exp_t q32[$];
  exp_t q24[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor for the 32-word instance: pops one expectation per dataValid pulse.
  always @(negedge clk) begin
    exp_t e;
    if (dv32 === 1'b1) begin
      if (q32.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut32_unexpected_valid: got dataValid=1 expected 0");
      end else begin
        e = q32.pop_front();
        chk($sformatf("t%0d_data", e.tag), {24'd0, readData32}, {24'd0, e.data});
        chk($sformatf("t%0d_err", e.tag), {31'd0, err32}, {31'd0, e.err});
      end
    end else if (err32 !== 1'b0) begin
      n_fail++;
      $display("FAIL dut32_err_outside_done: got %b expected 0", err32);
    end
  end

  // Monitor for the 24-word instance.
  always @(negedge clk) begin
    exp_t e;
    if (dv24 === 1'b1) begin
      if (q24.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut24_unexpected_valid: got dataValid=1 expected 0");
      end else begin
        e = q24.pop_front();
        chk($sformatf("t%0d_data", e.tag), {24'd0, readData24}, {24'd0, e.data});
        chk($sformatf("t%0d_err", e.tag), {31'd0, err24}, {31'd0, e.err});
      end
    end else if (err24 !== 1'b0) begin
      n_fail++;
      $display("FAIL dut24_err_outside_done: got %b expected 0", err24);
    end
  end

  // Called at a negedge: waits for ready, issues one request, checks latency.
  // With poke set, a write of 0xFF to address 4 is driven while the block is busy.
  task automatic req(input bit sel24, input bit rd, input bit wr, input logic [4:0] a,
                     input logic [7:0] wd, input logic [7:0] exp_d, input bit exp_e,
                     input int tag, input bit poke);
    int   n;
    exp_t e;
    n = 0;
    while (!(sel24 ? ready24 : ready32) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk($sformatf("t%0d_ready_timeout", tag), 32'd0, 32'd1);
    e.data = exp_d;
    e.err  = exp_e;
    e.tag  = tag;
    if (sel24) q24.push_back(e); else q32.push_back(e);
    address   = a;
    writeData = wd;
    if (sel24) begin rd24 = rd; wr24 = wr; end
    else       begin rd32 = rd; wr32 = wr; end
    @(posedge clk);
    #1;
    rd32 = 1'b0; wr32 = 1'b0; rd24 = 1'b0; wr24 = 1'b0;
    if (poke) begin
      address   = 5'd4;
      writeData = 8'hFF;
      if (sel24) wr24 = 1'b1; else wr32 = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (poke && n == 2) begin
        wr32 = 1'b0;
        wr24 = 1'b0;
      end
    end while (!(sel24 ? dv24 : dv32) && n < 20);
    chk($sformatf("t%0d_latency", tag), n, 32'd4);
  endtask

  // Called at the negedge where rst drops: counts cycles until each ready rises.
  task automatic wait_clear(input int tag);
    int c32, c24;
    c32 = 0;
    c24 = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ready32 && c32 == 0) c32 = i;
      if (ready24 && c24 == 0) c24 = i;
      if (c32 != 0 && c24 != 0) break;
    end
    chk($sformatf("clr%0d_ready32_cycles", tag), c32, 32'd32);
    chk($sformatf("clr%0d_ready24_cycles", tag), c24, 32'd24);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    address = '0; writeData = '0;
    rd32 = 1'b0; wr32 = 1'b0; rd24 = 1'b0; wr24 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready32", {31'd0, ready32}, 32'd0);
    chk("rst_valid32", {31'd0, dv32}, 32'd0);
    chk("rst_err32", {31'd0, err32}, 32'd0);
    chk("rst_rdata32", {24'd0, readData32}, 32'd0);
    chk("rst_ready24", {31'd0, ready24}, 32'd0);
    rst = 1'b0;
    wait_clear(0);

    // 32-word instance: cleared contents, write/read, read-before-write, busy ignore
    req(0, 1, 0, 5'd0,  8'h00, 8'h00, 0, 1,  0);
    req(0, 1, 0, 5'd31, 8'h00, 8'h00, 0, 2,  0);
    req(0, 0, 1, 5'd7,  8'hA5, 8'h00, 0, 3,  0);
    req(0, 1, 0, 5'd7,  8'h00, 8'hA5, 0, 4,  0);
    req(0, 0, 1, 5'd3,  8'h11, 8'hA5, 0, 5,  0);
    req(0, 1, 1, 5'd3,  8'h22, 8'h11, 0, 6,  0);
    req(0, 1, 0, 5'd3,  8'h00, 8'h22, 0, 7,  0);
    req(0, 0, 1, 5'd4,  8'h44, 8'h22, 0, 8,  0);
    req(0, 1, 0, 5'd5,  8'h00, 8'h00, 0, 9,  1);
    req(0, 1, 0, 5'd4,  8'h00, 8'h44, 0, 10, 0);

    // 24-word instance: range boundary
    req(1, 0, 1, 5'd25, 8'h5A, 8'h00, 1, 20, 0);
    req(1, 1, 0, 5'd25, 8'h00, 8'h00, 1, 21, 0);
    req(1, 0, 1, 5'd24, 8'h77, 8'h00, 1, 22, 0);
    req(1, 1, 0, 5'd24, 8'h00, 8'h00, 1, 23, 0);
    req(1, 0, 1, 5'd23, 8'h66, 8'h00, 0, 24, 0);
    req(1, 1, 0, 5'd23, 8'h00, 8'h66, 0, 25, 0);

    // Reset during the wait states of a read: no completion, memory re-cleared
    req(0, 0, 1, 5'd9, 8'h3C, 8'h44, 0, 11, 0);
    @(negedge clk);
    address = 5'd9;
    rd32    = 1'b1;
    @(posedge clk);
    #1;
    rd32 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ready32", {31'd0, ready32}, 32'd0);
    chk("abort_valid32", {31'd0, dv32}, 32'd0);
    chk("abort_rdata32", {24'd0, readData32}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_clear(1);
    req(0, 1, 0, 5'd9, 8'h00, 8'h00, 0, 30, 0);

    repeat (5) @(negedge clk);
    chk("q32_drained", q32.size(), 32'd0);
    chk("q24_drained", q24.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_sync_ctrl.md
Name: mem_sync_ctrl

Overview:
- Clocked, parametrised successor to the team's combinational byte memory.
- Adds a registered read path, a ready/valid request handshake and programmable wait states, so the multicycle datapath can model slow memory.
- Adds a hardware clear sequence after reset, replacing file-based initial contents.
- Address-range checking with an error flag.
- Sits between the multicycle control unit and the datapath as the single unified instruction/data memory.

Parameters:
WORD, 8, data word width in bits
LENGTH, 32, number of implemented words (1..2**ADDRESSL)
ADDRESSL, 5, address width in bits
WAIT_CYCLES, 2, extra wait states per access (>=0)

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  reset, asynchronous, active-high
address  input  ADDRESSL  word address, sampled at accept
writeData  input  WORD  write data, sampled at accept
memRead  input  1  read request
memWrite  input  1  write request
ready  output  1  block can accept a request this cycle
readData  output  WORD  registered read result
dataValid  output  1  one-cycle pulse: access complete
rangeErr  output  1  qualifies dataValid: address >= LENGTH

Behaviour:
- Reset (async, rst=1):
  - state=CLEAR, clear index=0.
  - ready=0, dataValid=0, rangeErr=0, readData=0.
  - Any pending request is discarded.
- States:
  - CLEAR: one word written per cycle, memory[idx]=0, idx++.
    - After the edge writing idx=LENGTH-1, go to IDLE.
    - ready first goes high LENGTH cycles after rst deasserts.
  - IDLE: ready=1.
    - On an edge with memRead|memWrite=1, accept the request.
    - Latch address, writeData, rd, wr; load wait counter with WAIT_CYCLES; go to WAIT.
    - With no request, stay in IDLE.
  - WAIT: ready=0.
    - If counter!=0: decrement.
    - Else perform the access on this edge and go to DONE.
  - DONE: lasts exactly one cycle; dataValid=1, ready=0; then IDLE.
- Latency:
  - Request accepted at edge k → access at edge k+WAIT_CYCLES+1.
  - dataValid high in the following cycle.
  - Next accept no earlier than edge k+WAIT_CYCLES+3.
- Access semantics:
  - Read: readData loaded at the access edge and held until the next read completion or reset.
  - Write: memory[addr]=writeData at the access edge; readData unchanged.
  - Read+write together: read-before-write. readData gets the old contents, then the new data is stored.
- Range:
  - If latched address >= LENGTH: no write; readData loaded with 0.
  - rangeErr=1 during the DONE cycle only; otherwise 0.
- Requests while ready=0 are ignored (not queued). Inputs are don't-care after accept.
- Reset mid-operation (any state): immediate return to CLEAR; memory is fully re-cleared; no dataValid pulse is issued for the aborted access.
- Counter width is sized for WAIT_CYCLES. WAIT_CYCLES=0 is legal and gives a 2-cycle access.

Test Plan:
- Reset then idle: rst pulse, release → ready=0 for exactly 32 cycles, then 1; a read of any address 0..31 returns 0x00 with rangeErr=0.
- Write/read, WAIT_CYCLES=2: write 0xA5 to address 7 accepted at edge k → dataValid at cycle k+3, readData unchanged. Read address 7 accepted at k+5 → readData=0xA5 with dataValid in cycle k+8.
- Read-before-write: mem[3]=0x11; memRead=memWrite=1, address=3, writeData=0x22 → readData=0x11; a subsequent read returns 0x22.
- Busy ignore: assert memWrite to address 4 with 0xFF while ready=0 (during WAIT) → no effect; a later read of address 4 returns the prior value.
- Out-of-range, LENGTH=24: write 0x5A to address 25, then read address 25 → both DONE cycles show rangeErr=1, read returns 0x00; address 24 is also flagged; address 23 is not.
- Reset mid-access: mem[9]=0x3C; rst asserted during WAIT of a read of address 9 → no dataValid; after re-clear, read of address 9 returns 0x00.
